// File: rtl/dtm_dmi_bridge.sv
// JTAG USER-chain to DMI bridge: DTMCS/DMI shift register on one side,
// a single-outstanding valid/ready debug request/response port on the other.
module dtm_dmi_bridge #(
  parameter int ABITS     = 7,
  parameter int IDLE_HINT = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sel,
  input  logic             reg_sel,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             tdi,
  output logic             tdo,
  output logic             debug_req_valid,
  input  logic             debug_req_ready,
  output logic [ABITS-1:0] debug_req_bits_addr,
  output logic [1:0]       debug_req_bits_op,
  output logic [31:0]      debug_req_bits_data,
  input  logic             debug_resp_valid,
  output logic             debug_resp_ready,
  input  logic [1:0]       debug_resp_bits_resp,
  input  logic [31:0]      debug_resp_bits_data,
  output logic             busy
);

  localparam int         W          = ABITS + 34;
  localparam logic [5:0] ABITS_FLD  = ABITS[5:0];
  localparam logic [2:0] IDLE_FLD   = IDLE_HINT[2:0];

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sr;
  logic [31:0]      rdata;
  logic [ABITS-1:0] last_addr;
  logic [ABITS-1:0] req_addr;
  logic [1:0]       req_op;
  logic [31:0]      req_data;
  logic             sticky_busy, sticky_err, drop;

  // Strobe decode: update beats capture beats shift.
  logic do_update, do_capture, do_shift;
  logic dmi_update, dtmcs_update;
  assign do_update    = sel & update;
  assign do_capture   = sel & capture & ~update;
  assign do_shift     = sel & shift & ~capture & ~update;
  assign dmi_update   = do_update & reg_sel;
  assign dtmcs_update = do_update & ~reg_sel;

  logic [1:0]       upd_op;
  logic [31:0]      upd_data;
  logic [ABITS-1:0] upd_addr;
  assign upd_op   = sr[1:0];
  assign upd_data = sr[33:2];
  assign upd_addr = sr[W-1:34];

  logic stickies_clear, dmi_issue, dmi_collide, req_fire, resp_fire;
  assign stickies_clear = ~sticky_busy & ~sticky_err;
  assign dmi_issue      = dmi_update & stickies_clear & (state_q == IDLE) &
                          ((upd_op == 2'd1) | (upd_op == 2'd2));
  assign dmi_collide    = dmi_update & stickies_clear & (state_q != IDLE);
  assign req_fire       = (state_q == REQ) & debug_req_ready;
  assign resp_fire      = (state_q == RESP) & debug_resp_valid;

  logic [1:0] status;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    status = 2'd0;
    if (sticky_busy)     status = 2'd3;
    else if (sticky_err) status = 2'd2;
  end

  logic [31:0] dtmcs_word;
  assign dtmcs_word = {14'b0, 2'b0, 1'b0, IDLE_FLD, status, ABITS_FLD, 4'd1};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dmi_issue) state_d = REQ;
      REQ:     if (req_fire)  state_d = RESP;
      RESP:    if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so all
  // registers sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr          <= '0;
      rdata       <= '0;
      last_addr   <= '0;
      req_addr    <= '0;
      req_op      <= '0;
      req_data    <= '0;
      sticky_busy <= 1'b0;
      sticky_err  <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (do_shift) begin
        if (reg_sel) sr       <= {tdi, sr[W-1:1]};
        else         sr[31:0] <= {tdi, sr[31:1]};
      end else if (do_capture) begin
        if (reg_sel) sr       <= {last_addr, rdata, status};
        else         sr[31:0] <= dtmcs_word;
      end

      // Response first, so a colliding DMI update still sees a busy bridge.
      if (resp_fire) begin
        if (!drop) begin
          rdata <= debug_resp_bits_data;
          if (debug_resp_bits_resp != 2'd0) sticky_err <= 1'b1;
        end
        drop <= 1'b0;
      end

      if (dmi_issue) begin
        req_addr  <= upd_addr;
        req_op    <= upd_op;
        req_data  <= upd_data;
        last_addr <= upd_addr;
      end

      if (dmi_collide) sticky_busy <= 1'b1;

      if (dtmcs_update && (sr[16] || sr[17])) begin
        sticky_busy <= 1'b0;
        sticky_err  <= 1'b0;
      end

      // Only mark for discard if a transaction will still be in flight.
      if (dtmcs_update && sr[17] && (state_d != IDLE)) drop <= 1'b1;
    end
  end

  assign tdo                 = rstn & sr[0];
  assign debug_req_valid     = rstn & (state_q == REQ);
  assign debug_resp_ready    = rstn & (state_q == RESP);
  assign busy                = rstn & (state_q != IDLE);
  assign debug_req_bits_addr = rstn ? req_addr : '0;
  assign debug_req_bits_op   = rstn ? req_op   : '0;
  assign debug_req_bits_data = rstn ? req_data : '0;

endmodule

// File: tb/tb_dtm_dmi_bridge.sv
// Directed + randomized bench for dtm_dmi_bridge; a transaction-level model
// predicts capture contents, request bits and busy behaviour.
module tb_dtm_dmi_bridge;

  localparam int ABITS = 7;
  localparam int W     = ABITS + 34;

  logic             clk = 1'b0;
  logic             rstn, sel, reg_sel, capture, shift, update, tdi, tdo;
  logic             debug_req_valid, debug_req_ready;
  logic [ABITS-1:0] debug_req_bits_addr;
  logic [1:0]       debug_req_bits_op;
  logic [31:0]      debug_req_bits_data;
  logic             debug_resp_valid, debug_resp_ready;
  logic [1:0]       debug_resp_bits_resp;
  logic [31:0]      debug_resp_bits_data;
  logic             busy;

  always #5 clk = ~clk;

  dtm_dmi_bridge #(.ABITS(ABITS), .IDLE_HINT(5)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .sel                  (sel),
    .reg_sel              (reg_sel),
    .capture              (capture),
    .shift                (shift),
    .update               (update),
    .tdi                  (tdi),
    .tdo                  (tdo),
    .debug_req_valid      (debug_req_valid),
    .debug_req_ready      (debug_req_ready),
    .debug_req_bits_addr  (debug_req_bits_addr),
    .debug_req_bits_op    (debug_req_bits_op),
    .debug_req_bits_data  (debug_req_bits_data),
    .debug_resp_valid     (debug_resp_valid),
    .debug_resp_ready     (debug_resp_ready),
    .debug_resp_bits_resp (debug_resp_bits_resp),
    .debug_resp_bits_data (debug_resp_bits_data),
    .busy                 (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural view of the bridge.
  logic [ABITS-1:0] m_last_addr;
  logic [31:0]      m_rdata;
  bit               m_sbusy, m_serr;

  function automatic logic [1:0] m_status();
    if (m_sbusy) return 2'd3;
    if (m_serr)  return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_dtmcs();
    return 32'd1 + (32'(ABITS) << 4) + (32'(m_status()) << 10) + (32'd5 << 12);
  endfunction

  function automatic logic [W-1:0] m_dmi();
    return {m_last_addr, m_rdata, m_status()};
  endfunction

  function automatic logic [W-1:0] pack(input logic [1:0] op, input logic [ABITS-1:0] a,
                                        input logic [31:0] d);
    return {a, d, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dmi_scan(input logic [W-1:0] din, input bit upd, input bit resp_too,
                          output logic [W-1:0] dout);
    sel = 1'b1; reg_sel = 1'b1; capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < W; i++) begin
      shift = 1'b1; tdi = din[i]; dout[i] = tdo;
      tick();
    end
    shift = 1'b0;
    if (upd) begin
      update = 1'b1;
      if (resp_too) debug_resp_valid = 1'b1;
      tick();
      update = 1'b0; debug_resp_valid = 1'b0;
    end
    sel = 1'b0;
  endtask

  task automatic dtmcs_scan(input logic [31:0] din, input bit upd, output logic [31:0] dout);
    sel = 1'b1; reg_sel = 1'b0; capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 32; i++) begin
      shift = 1'b1; tdi = din[i]; dout[i] = tdo;
      tick();
    end
    shift = 1'b0;
    if (upd) begin
      update = 1'b1;
      tick();
      update = 1'b0;
    end
    sel = 1'b0;
  endtask

  task automatic model_reset();
    m_last_addr = '0; m_rdata = '0; m_sbusy = 0; m_serr = 0;
  endtask

  initial begin
    logic [W-1:0]     dout, exp41;
    logic [31:0]      d32, rd, data;
    logic [ABITS-1:0] addr;
    logic [1:0]       op, rc;
    bit               accepted;

    rstn = 1'b0; sel = 0; reg_sel = 0; capture = 0; shift = 0; update = 0; tdi = 0;
    debug_req_ready = 0; debug_resp_valid = 0; debug_resp_bits_resp = 0; debug_resp_bits_data = 0;
    model_reset();
    tick();
    repeat (3) tick();

    // Reset state
    check("rst_valid", debug_req_valid, 0);
    check("rst_resp_ready", debug_resp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_tdo", tdo, 0);
    check("rst_req_bits", {debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data}, 0);
    rstn = 1'b1;
    tick();

    // DTMCS capture stream
    dtmcs_scan(32'h0, 0, d32);
    check("dtmcs_const", d32, 32'h0000_5071);
    check("dtmcs_model", d32, m_dtmcs());

    // Write with ready tied high
    debug_req_ready = 1'b1;
    dmi_scan(pack(2'd2, 7'h10, 32'hDEADBEEF), 1, 0, dout);
    check("wr_cap", dout, m_dmi());
    m_last_addr = 7'h10;
    check("wr_valid", debug_req_valid, 1);
    check("wr_addr", debug_req_bits_addr, 7'h10);
    check("wr_op", debug_req_bits_op, 2'd2);
    check("wr_data", debug_req_bits_data, 32'hDEADBEEF);
    tick();
    debug_req_ready = 1'b0;
    check("wr_valid_one_cycle", debug_req_valid, 0);
    check("wr_busy_resp", busy, 1);
    check("wr_resp_ready", debug_resp_ready, 1);
    debug_resp_valid = 1'b1; debug_resp_bits_data = 32'hCAFE0001; debug_resp_bits_resp = 2'd0;
    tick();
    debug_resp_valid = 1'b0;
    m_rdata = 32'hCAFE0001;
    check("wr_busy_fall", busy, 0);

    // Read 0x11 then capture
    debug_req_ready = 1'b1;
    dmi_scan(pack(2'd1, 7'h11, 32'h0), 1, 0, dout);
    check("rd_cap_pre", dout, m_dmi());
    m_last_addr = 7'h11;
    tick();
    debug_req_ready = 1'b0;
    debug_resp_valid = 1'b1; debug_resp_bits_data = 32'h1234_5678; debug_resp_bits_resp = 2'd0;
    tick();
    debug_resp_valid = 1'b0;
    m_rdata = 32'h1234_5678;
    dmi_scan('0, 0, 0, dout);
    exp41 = {7'h11, 32'h12345678, 2'b00};
    check("rd_cap_const", dout, exp41);
    check("rd_cap_model", dout, m_dmi());

    // Collision while ready held low -> sticky busy
    dmi_scan(pack(2'd2, 7'h22, 32'h0BAD_F00D), 1, 0, dout);
    m_last_addr = 7'h22;
    check("coll_first_valid", debug_req_valid, 1);
    dmi_scan(pack(2'd1, 7'h33, 32'h0), 1, 0, dout);
    check("coll_cap", dout, m_dmi());
    m_sbusy = 1;
    check("coll_still_valid", debug_req_valid, 1);
    check("coll_addr_held", debug_req_bits_addr, 7'h22);
    debug_req_ready = 1'b1; tick(); debug_req_ready = 1'b0;
    debug_resp_valid = 1'b1; debug_resp_bits_data = 32'h0000_00AA; tick(); debug_resp_valid = 1'b0;
    m_rdata = 32'h0000_00AA;
    dmi_scan(pack(2'd2, 7'h44, 32'h1), 1, 0, dout);
    check("sticky_busy_cap", dout, m_dmi());
    check("sticky_busy_status", dout[1:0], 2'd3);
    check("sticky_ignored_busy", busy, 0);
    dtmcs_scan(32'h0001_0000, 1, d32);
    check("sticky_busy_dmistat", d32, m_dtmcs());
    m_sbusy = 0;
    dmi_scan('0, 0, 0, dout);
    check("dmireset_cap", dout, m_dmi());
    check("dmireset_status", dout[1:0], 2'd0);

    // Error response, then hard reset mid-RESP
    debug_req_ready = 1'b1;
    dmi_scan(pack(2'd1, 7'h55, 32'h0), 1, 0, dout);
    m_last_addr = 7'h55;
    tick();
    debug_req_ready = 1'b0;
    debug_resp_valid = 1'b1; debug_resp_bits_data = 32'h5555_0002; debug_resp_bits_resp = 2'd2;
    tick();
    debug_resp_valid = 1'b0; debug_resp_bits_resp = 2'd0;
    m_rdata = 32'h5555_0002; m_serr = 1;
    dmi_scan('0, 0, 0, dout);
    check("err_cap", dout, m_dmi());
    check("err_status", dout[1:0], 2'd2);
    dtmcs_scan(32'h0001_0000, 1, d32);
    check("err_dmistat", d32, m_dtmcs());
    m_serr = 0;
    debug_req_ready = 1'b1;
    dmi_scan(pack(2'd1, 7'h66, 32'h0), 1, 0, dout);
    m_last_addr = 7'h66;
    tick();
    debug_req_ready = 1'b0;
    check("hard_in_resp", debug_resp_ready, 1);
    dtmcs_scan(32'h0002_0000, 1, d32);
    check("hard_dtmcs_cap", d32, m_dtmcs());
    check("hard_still_busy", busy, 1);
    debug_resp_valid = 1'b1; debug_resp_bits_data = 32'hFFFF_FFFF; debug_resp_bits_resp = 2'd3;
    tick();
    debug_resp_valid = 1'b0; debug_resp_bits_resp = 2'd0;
    check("hard_busy_fall", busy, 0);
    dmi_scan('0, 0, 0, dout);
    check("hard_rdata_kept", dout, m_dmi());

    // Response in the same cycle as a DMI update
    debug_req_ready = 1'b1;
    dmi_scan(pack(2'd2, 7'h12, 32'h0000_1212), 1, 0, dout);
    m_last_addr = 7'h12;
    tick();
    debug_req_ready = 1'b0;
    debug_resp_bits_data = 32'h0C0F_FEE0; debug_resp_bits_resp = 2'd0;
    dmi_scan(pack(2'd1, 7'h13, 32'h0), 1, 1, dout);
    m_rdata = 32'h0C0F_FEE0; m_sbusy = 1;
    check("same_cyc_busy", busy, 0);
    check("same_cyc_no_req", debug_req_valid, 0);
    dmi_scan('0, 0, 0, dout);
    check("same_cyc_cap", dout, m_dmi());
    dtmcs_scan(32'h0001_0000, 1, d32);
    check("same_cyc_dmistat", d32, m_dtmcs());
    m_sbusy = 0;

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3)); addr = ABITS'($urandom); data = $urandom;
      accepted = !m_sbusy && !m_serr && (op == 2'd1 || op == 2'd2);
      dmi_scan(pack(op, addr, data), 1, 0, dout);
      check("rnd_cap", dout, m_dmi());
      if (!accepted) begin
        check("rnd_idle_busy", busy, 0);
        check("rnd_idle_valid", debug_req_valid, 0);
        if (m_sbusy || m_serr) begin
          dtmcs_scan(32'h0001_0000, 1, d32);
          check("rnd_dtmcs", d32, m_dtmcs());
          m_sbusy = 0; m_serr = 0;
        end
      end else begin
        m_last_addr = addr;
        check("rnd_valid", debug_req_valid, 1);
        check("rnd_bits", {debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data},
              {addr, op, data});
        repeat ($urandom_range(0, 3)) begin
          tick();
          check("rnd_valid_hold", debug_req_valid, 1);
        end
        debug_req_ready = 1'b1; tick(); debug_req_ready = 1'b0;
        check("rnd_resp_ready", debug_resp_ready, 1);
        check("rnd_req_dropped", debug_req_valid, 0);
        repeat ($urandom_range(0, 3)) tick();
        rd = $urandom;
        rc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        debug_resp_valid = 1'b1; debug_resp_bits_data = rd; debug_resp_bits_resp = rc;
        tick();
        debug_resp_valid = 1'b0; debug_resp_bits_resp = 2'd0;
        check("rnd_busy_fall", busy, 0);
        m_rdata = rd;
        if (rc != 2'd0) m_serr = 1;
      end
    end
    dtmcs_scan(32'h0001_0000, 1, d32);
    check("rnd_final_dtmcs", d32, m_dtmcs());
    m_sbusy = 0; m_serr = 0;

    // Reset in the middle of a request
    dmi_scan(pack(2'd2, 7'h7A, 32'h7A7A_7A7A), 1, 0, dout);
    check("mid_rst_valid_pre", debug_req_valid, 1);
    rstn = 1'b0;
    tick();
    check("mid_rst_valid", debug_req_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tdo", tdo, 0);
    check("mid_rst_bits", {debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data}, 0);
    rstn = 1'b1;
    model_reset();
    tick();
    debug_req_ready = 1'b1;
    dmi_scan(pack(2'd2, 7'h05, 32'h0505_0505), 1, 0, dout);
    check("post_rst_cap", dout, m_dmi());
    check("post_rst_valid", debug_req_valid, 1);
    check("post_rst_addr", debug_req_bits_addr, 7'h05);
    tick();
    debug_req_ready = 1'b0;
    check("post_rst_handshake", debug_req_valid, 0);
    debug_resp_valid = 1'b1; debug_resp_bits_data = 32'h0; tick(); debug_resp_valid = 1'b0;
    check("post_rst_busy_fall", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dtm_dmi_bridge.md
DTM_DMI_BRIDGE -- requirements
Module: dtm_dmi_bridge

Interface
REQ-001 SHALL have parameter ABITS, default 7, meaning DMI address width (legal 7..32).
REQ-002 SHALL have parameter IDLE_HINT, default 5, meaning the value reported in the dtmcs.idle field (3 bits).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset; synchronous, active-low.
REQ-005 sel  in  1  USER chain selected; capture, shift and update are ignored when low.
REQ-006 reg_sel  in  1  0 = DTMCS register (32 bits), 1 = DMI register (ABITS+34 bits).
REQ-007 capture, shift, update  in  1 each  single-cycle strobes, already synchronised to clk.
REQ-008 tdi  in  1  serial data in; tdo  out  1  serial data out, equal to sr[0] (combinational).
REQ-009 debug_req_valid out 1, debug_req_ready in 1, debug_req_bits_addr out ABITS, debug_req_bits_op out 2, debug_req_bits_data out 32.
REQ-010 debug_resp_valid in 1, debug_resp_ready out 1, debug_resp_bits_resp in 2, debug_resp_bits_data in 32.
REQ-011 busy  out  1  high while a DMI transaction is outstanding (state != IDLE).

Function
REQ-012 Shift register sr SHALL be ABITS+34 bits wide; DTMCS operations use only sr[31:0].
REQ-013 Strobe priority when asserted together SHALL be update > capture > shift.
REQ-014 Shift SHALL load sr <= {tdi, sr[W-1:1]}, where W = 32 (reg_sel=0) or ABITS+34 (reg_sel=1).
REQ-015 DMI capture SHALL load sr <= {last_addr, rdata, status}. status = 3 if sticky_busy, else 2 if sticky_err, else 0.
REQ-016 DTMCS capture SHALL load sr[31:0] <= {14'b0, 2'b0, 1'b0, IDLE_HINT[2:0], dmistat, ABITS[5:0], 4'd1}. dmistat uses the same encoding as status in REQ-015.
REQ-017 DMI update SHALL decode op = sr[1:0], data = sr[33:2] and addr = sr[ABITS+33:34].
REQ-018 DMI update SHALL be ignored entirely if sticky_busy or sticky_err is set.
REQ-019 DMI update while busy SHALL set sticky_busy and issue nothing.
REQ-020 DMI update in IDLE with op 1 (read) or 2 (write) SHALL latch addr, data and op into the request regs, set last_addr = addr, and enter REQ. op 0 or 3 SHALL have no effect.
REQ-021 FSM states SHALL be IDLE, REQ and RESP.
REQ-022 In REQ, debug_req_valid SHALL be 1 and the request bits SHALL be held stable. On debug_req_valid && debug_req_ready the FSM SHALL go to RESP on the next cycle.
REQ-023 In RESP, debug_resp_ready SHALL be 1. On debug_resp_valid the block SHALL latch rdata = debug_resp_bits_data, set sticky_err if debug_resp_bits_resp != 0, and return to IDLE.
REQ-024 Request-to-IDLE latency SHALL be at least 2 cycles: one handshake cycle plus one response cycle.
REQ-025 DTMCS update with sr[16] (dmireset) SHALL clear sticky_busy and sticky_err.
REQ-026 DTMCS update with sr[17] (dmihardreset) SHALL clear both stickies and set drop. The outstanding transaction still completes its handshakes, but its rdata and error are discarded; drop clears on return to IDLE.
REQ-027 rdata SHALL hold its value until the next accepted response that is not dropped.
REQ-028 A response arriving in the same cycle as a DMI update SHALL be processed first. The update then sees IDLE only on the following cycle, so it sets sticky_busy.

Reset
REQ-029 On rstn=0 at a clk edge, the block SHALL set state=IDLE, sr=0, rdata=0, last_addr=0, stickies=0 and drop=0.
REQ-030 During reset, debug_req_valid=0, debug_resp_ready=0, busy=0 and tdo=0; outputs carrying request bits SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction immediately; the bench SHALL tolerate the orphaned response.

Verification
REQ-032 DTMCS capture, then 32 shifts, with ABITS=7 -> tdo stream LSB-first = 32'h0000_5071.
REQ-033 DMI update op=2, addr=7'h10, data=32'hDEADBEEF, ready tied 1 -> valid high for exactly 1 cycle carrying those bits; busy falls 1 cycle after resp_valid.
REQ-034 Read addr 7'h11 with resp_data=32'h1234_5678 and resp=0, then DMI capture -> sr = {7'h11, 32'h12345678, 2'b00}.
REQ-035 Second DMI update while ready is held 0 -> sticky_busy set, capture status=3. Further updates are ignored until DTMCS dmireset, after which status=0.
REQ-036 resp=2 on a read -> status=2. Then DTMCS dmihardreset mid-RESP -> status=0, and rdata is unchanged after the late response.
REQ-037 rstn=0 asserted in REQ -> next cycle valid=0 and state=IDLE; a subsequent write issues normally.
